// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: fetch, register-file, forwarding and ID/EX output bundle of the operand stage
interface id_ex_operand_stage_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
   logic             if_valid;
   logic [31:0]      if_instr;
   logic [XLEN-1:0]  if_pc;
   logic             if_ready;
   logic             flush;
   logic [4:0]       rf_read_address_1;
   logic [4:0]       rf_read_address_2;
   logic [XLEN-1:0]  rf_data_1;
   logic [XLEN-1:0]  rf_data_2;
   logic             exmem_valid;
   logic             exmem_reg_write;
   logic [4:0]       exmem_rd;
   logic [XLEN-1:0]  exmem_result;
   logic             memwb_valid;
   logic             memwb_reg_write;
   logic [4:0]       memwb_rd;
   logic [XLEN-1:0]  memwb_result;
   logic             e_valid;
   logic [XLEN-1:0]  e_pc;
   logic [31:0]      e_instr;
   logic [4:0]       e_rd;
   logic             e_is_load;
   logic [XLEN-1:0]  e_imm;
   logic [XLEN-1:0]  e_op_a;
   logic [XLEN-1:0]  e_op_b;
   logic [1:0]       e_fwd_a;
   logic [1:0]       e_fwd_b;
   logic [CNT_W-1:0] stall_count;
   modport slave (
      input  if_valid, if_instr, if_pc, flush, rf_data_1, rf_data_2,
             exmem_valid, exmem_reg_write, exmem_rd, exmem_result,
             memwb_valid, memwb_reg_write, memwb_rd, memwb_result,
      output if_ready, rf_read_address_1, rf_read_address_2,
             e_valid, e_pc, e_instr, e_rd, e_is_load, e_imm,
             e_op_a, e_op_b, e_fwd_a, e_fwd_b, stall_count
   );
   modport master (
      output if_valid, if_instr, if_pc, flush, rf_data_1, rf_data_2,
             exmem_valid, exmem_reg_write, exmem_rd, exmem_result,
             memwb_valid, memwb_reg_write, memwb_rd, memwb_result,
      input  if_ready, rf_read_address_1, rf_read_address_2,
             e_valid, e_pc, e_instr, e_rd, e_is_load, e_imm,
             e_op_a, e_op_b, e_fwd_a, e_fwd_b, stall_count
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: decode into the ID/EX register with EX/MEM and MEM/WB forwarding and load-use bubbles
module id_ex_operand_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic                    clock,
   input logic                    reset,
   id_ex_operand_stage_if.slave   bus
);
   localparam logic [6:0] OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111,
                          OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111,
                          OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_R = 7'b0110011;
   logic             e_valid_q, e_valid_d, e_is_load_q, e_is_load_d;
   logic [XLEN-1:0]  e_pc_q, e_pc_d, e_imm_q, e_imm_d;
   logic [31:0]      e_instr_q, e_instr_d, imm32;
   logic [4:0]       e_rd_q, e_rd_d, rs1, rs2;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic [6:0]       opc;
   logic             stall, capture;
   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction
   function automatic logic uses_rs2(input logic [6:0] op);
      return op == OP_R || op == OP_S || op == OP_B;
   endfunction
   // x0 never forwards; EX/MEM outranks MEM/WB because it is the younger producer
   function automatic logic [1:0] fwd_sel(input logic use_it, input logic [4:0] rs,
                                          input logic ex_ok, input logic [4:0] ex_rd,
                                          input logic wb_ok, input logic [4:0] wb_rd);
      return (!use_it || rs == 5'd0) ? 2'd0 : (ex_ok && ex_rd == rs) ? 2'd1 :
             (wb_ok && wb_rd == rs) ? 2'd2 : 2'd0;
   endfunction
   always_comb begin
      opc = bus.if_instr[6:0];
      rs1 = bus.if_instr[19:15];
      rs2 = bus.if_instr[24:20];
      imm32 = (opc == OP_IMM || opc == OP_LOAD || opc == OP_JALR) ? {{20{bus.if_instr[31]}}, bus.if_instr[31:20]} :
              (opc == OP_S) ? {{20{bus.if_instr[31]}}, bus.if_instr[31:25], bus.if_instr[11:7]} :
              (opc == OP_B) ? {{20{bus.if_instr[31]}}, bus.if_instr[7], bus.if_instr[30:25], bus.if_instr[11:8], 1'b0} :
              (opc == OP_LUI || opc == OP_AUIPC) ? {bus.if_instr[31:12], 12'b0} :
              (opc == OP_JAL) ? {{12{bus.if_instr[31]}}, bus.if_instr[19:12], bus.if_instr[20], bus.if_instr[30:21], 1'b0} :
              32'd0;
      stall = e_valid_q & e_is_load_q & (e_rd_q != 5'd0) & bus.if_valid &
              ((uses_rs1(opc) & rs1 == e_rd_q) | (uses_rs2(opc) & rs2 == e_rd_q));
      capture = ~bus.flush & ~stall;
      e_valid_d = capture & bus.if_valid;
      e_pc_d = capture ? bus.if_pc : e_pc_q;
      e_instr_d = capture ? bus.if_instr : e_instr_q;
      e_rd_d = !capture ? e_rd_q : (opc == OP_S || opc == OP_B) ? 5'd0 : bus.if_instr[11:7];
      e_is_load_d = capture ? (opc == OP_LOAD) : e_is_load_q;
      e_imm_d = capture ? XLEN'($signed(imm32)) : e_imm_q;
      stall_count_d = (stall & ~bus.flush & ~&stall_count_q) ? stall_count_q + CNT_W'(1) : stall_count_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         e_valid_q <= 1'b0;
         e_pc_q <= '0;
         e_instr_q <= '0;
         e_rd_q <= '0;
         e_is_load_q <= 1'b0;
         e_imm_q <= '0;
         stall_count_q <= '0;
      end else begin
         e_valid_q <= e_valid_d;
         e_pc_q <= e_pc_d;
         e_instr_q <= e_instr_d;
         e_rd_q <= e_rd_d;
         e_is_load_q <= e_is_load_d;
         e_imm_q <= e_imm_d;
         stall_count_q <= stall_count_d;
      end
   end
   always_comb begin
      bus.if_ready = ~stall;
      bus.rf_read_address_1 = rs1;
      bus.rf_read_address_2 = rs2;
      bus.e_valid = e_valid_q;
      bus.e_pc = e_pc_q;
      bus.e_instr = e_instr_q;
      bus.e_rd = e_rd_q;
      bus.e_is_load = e_is_load_q;
      bus.e_imm = e_imm_q;
      bus.stall_count = stall_count_q;
      bus.e_fwd_a = fwd_sel(e_valid_q & uses_rs1(e_instr_q[6:0]), e_instr_q[19:15],
                            bus.exmem_valid & bus.exmem_reg_write, bus.exmem_rd,
                            bus.memwb_valid & bus.memwb_reg_write, bus.memwb_rd);
      bus.e_fwd_b = fwd_sel(e_valid_q & uses_rs2(e_instr_q[6:0]), e_instr_q[24:20],
                            bus.exmem_valid & bus.exmem_reg_write, bus.exmem_rd,
                            bus.memwb_valid & bus.memwb_reg_write, bus.memwb_rd);
      bus.e_op_a = (bus.e_fwd_a == 2'd1) ? bus.exmem_result : (bus.e_fwd_a == 2'd2) ? bus.memwb_result : bus.rf_data_1;
      bus.e_op_b = (bus.e_fwd_b == 2'd1) ? bus.exmem_result : (bus.e_fwd_b == 2'd2) ? bus.memwb_result : bus.rf_data_2;
   end
endmodule
